// File: rtl/img_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// img_pkg: shared image-pipeline types and address-width helper
// Rev 1.0
// ------------------------------------------------------------------
package img_pkg;

  localparam int IMG_WIDTH_DFLT  = 41;
  localparam int IMG_HEIGHT_DFLT = 50;
  localparam int DATA_W_DFLT     = 18;
  localparam int W_X             = $clog2(IMG_WIDTH_DFLT);
  localparam int W_Y             = $clog2(IMG_HEIGHT_DFLT);

  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

  typedef logic [W_X-1:0] coord_x_t;
  typedef logic [W_Y-1:0] coord_y_t;

  typedef struct packed {
    logic [DATA_W_DFLT-1:0] data;
    coord_x_t               x;
    coord_y_t               y;
  } fetch_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_fifo: single-clock FIFO; head data, full and count come from flops
// Rev 1.0
// ------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_wr, do_rd;

  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_rd = rd_en_i & (count_q != '0);
  assign do_wr = wr_en_i & (~full_o | do_rd);

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/img_rd_fetch.sv
`default_nettype none
// ------------------------------------------------------------------
// img_rd_fetch: linearises (x,y) into RAM reads, returns tagged words
// Rev 1.0
// ------------------------------------------------------------------
module img_rd_fetch
  import img_pkg::*;
#(
  parameter  int IMG_WIDTH  = 41,
  parameter  int IMG_HEIGHT = 50,
  parameter  int DATA_W     = 18,
  parameter  int RD_LATENCY = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int W_X        = $clog2(IMG_WIDTH),
  localparam int W_Y        = $clog2(IMG_HEIGHT),
  localparam int ADDR_W     = addr_w(IMG_WIDTH, IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_valid_i,
  output logic              addr_ready_o,
  input  logic [W_X-1:0]    x_i,
  input  logic [W_Y-1:0]    y_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [W_X-1:0]    data_x_o,
  output logic [W_Y-1:0]    data_y_o,
  output logic              range_err_o
);

  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_W = DATA_W + W_X + W_Y;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_chk
    $error("img_rd_fetch: RD_LATENCY must be in 1..4");
  end
  if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_depth_chk
    $error("img_rd_fetch: FIFO_DEPTH must be >= RD_LATENCY+1");
  end

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              issue, pop, out_of_range;
  logic [RD_LATENCY-1:0] tv_q;
  logic [W_X-1:0]    tx_q [RD_LATENCY];
  logic [W_Y-1:0]    ty_q [RD_LATENCY];
  logic              fifo_wr, fifo_full;
  logic [FIFO_W-1:0] fifo_head;
  logic [OCC_W-1:0]  fifo_cnt;
  logic              range_err_q;

  assign mem_addr_o = ADDR_W'((ADDR_W+1)'(y_i) * (ADDR_W+1)'(IMG_WIDTH) + (ADDR_W+1)'(x_i));

  // Credits cover both in-flight reads and buffered words, so the FIFO never overflows.
  assign addr_ready_o = (occ_q < OCC_W'(FIFO_DEPTH)) & ~rst;
  assign issue        = addr_valid_i & addr_ready_o;
  assign mem_rd_en_o  = issue;
  assign pop          = data_valid_o & data_ready_i;
  assign out_of_range = (32'(x_i) >= IMG_WIDTH) | (32'(y_i) >= IMG_HEIGHT);

  always_comb begin
    occ_d = occ_q;
    case ({issue, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= '0;
      range_err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (issue && out_of_range) range_err_q <= 1'b1;
    end
  end

  // Tag pipe mirrors the RAM latency and never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q <= '0;
    end else begin
      tv_q[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) tv_q[i] <= tv_q[i-1];
    end
    tx_q[0] <= x_i;
    ty_q[0] <= y_i;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tx_q[i] <= tx_q[i-1];
      ty_q[i] <= ty_q[i-1];
    end
  end

  assign fifo_wr = tv_q[RD_LATENCY-1] & (~fifo_full | pop);

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({mem_rd_data_i, tx_q[RD_LATENCY-1], ty_q[RD_LATENCY-1]}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .count_o   (fifo_cnt)
  );

  assign data_valid_o = (fifo_cnt != '0) & ~rst;
  assign data_o       = fifo_head[FIFO_W-1 -: DATA_W];
  assign data_x_o     = fifo_head[W_X+W_Y-1 -: W_X];
  assign data_y_o     = fifo_head[W_Y-1:0];
  assign range_err_o  = range_err_q;

endmodule
`default_nettype wire

// File: tb/tb_img_rd_fetch.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_img_rd_fetch: scoreboard bench, two instances (RD_LATENCY 1 and 3)
// Rev 1.0
// ------------------------------------------------------------------
module tb_img_rd_fetch;

  localparam int IW = 41;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       addr_valid = 1'b0;
  logic [5:0] x = '0;
  logic [5:0] y = '0;
  logic       data_ready = 1'b0;

  logic        addr_ready  [2];
  logic        mem_rd_en   [2];
  logic [11:0] mem_addr    [2];
  logic [17:0] mem_rd_data [2];
  logic        data_valid  [2];
  logic [17:0] data        [2];
  logic [5:0]  data_x      [2];
  logic [5:0]  data_y      [2];
  logic        range_err   [2];

  int checks = 0;
  int errors = 0;
  int acc_cnt [2] = '{0, 0};
  int pop_cnt [2] = '{0, 0};

  typedef struct {
    logic [17:0] d;
    logic [5:0]  x;
    logic [5:0]  y;
  } exp_t;
  exp_t sb [2][$];

  always #5 clk = ~clk;

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 5;
  endfunction

  function automatic logic [11:0] ref_addr(input int xx, input int yy);
    return 12'(yy * IW + xx);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;
    logic [11:0] ram_q [L];

    img_rd_fetch #(
      .IMG_WIDTH  (41),
      .IMG_HEIGHT (50),
      .DATA_W     (18),
      .RD_LATENCY (L),
      .FIFO_DEPTH ((gi == 0) ? 4 : 5)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .addr_valid_i  (addr_valid),
      .addr_ready_o  (addr_ready[gi]),
      .x_i           (x),
      .y_i           (y),
      .mem_rd_en_o   (mem_rd_en[gi]),
      .mem_addr_o    (mem_addr[gi]),
      .mem_rd_data_i (mem_rd_data[gi]),
      .data_valid_o  (data_valid[gi]),
      .data_ready_i  (data_ready),
      .data_o        (data[gi]),
      .data_x_o      (data_x[gi]),
      .data_y_o      (data_y[gi]),
      .range_err_o   (range_err[gi])
    );

    // RAM model: word at address a is a ^ 'h155, L cycles after the read
    always @(posedge clk) begin
      ram_q[0] <= mem_addr[gi];
      for (int k = 1; k < L; k++) ram_q[k] <= ram_q[k-1];
    end
    assign mem_rd_data[gi] = {6'd0, ram_q[L-1]} ^ 18'h155;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: credit rule, issue rule, ordered delivery against the scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sb[i].delete();
        check($sformatf("rst_dv%0d", i), 32'(data_valid[i]), 0);
        check($sformatf("rst_ready%0d", i), 32'(addr_ready[i]), 0);
        check($sformatf("rst_rden%0d", i), 32'(mem_rd_en[i]), 0);
      end else begin
        check($sformatf("ready%0d", i), 32'(addr_ready[i]), 32'(sb[i].size() < dep(i)));
        check($sformatf("rden%0d", i), 32'(mem_rd_en[i]), 32'(addr_valid && addr_ready[i]));
        if (data_valid[i] === 1'b1 && data_ready) begin
          pop_cnt[i]++;
          if (sb[i].size() == 0) begin
            check($sformatf("unexpected_beat%0d", i), 32'(data[i]), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = sb[i].pop_front();
            check($sformatf("data%0d", i), 32'(data[i]), 32'(e.d));
            check($sformatf("tagx%0d", i), 32'(data_x[i]), 32'(e.x));
            check($sformatf("tagy%0d", i), 32'(data_y[i]), 32'(e.y));
          end
        end
        if (mem_rd_en[i] === 1'b1) begin
          exp_t n;
          acc_cnt[i]++;
          n.x = x;
          n.y = y;
          n.d = {6'd0, ref_addr(int'(x), int'(y))} ^ 18'h155;
          check($sformatf("addr%0d", i), 32'(mem_addr[i]), 32'(ref_addr(int'(x), int'(y))));
          sb[i].push_back(n);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    addr_valid = 1'b0;
    data_ready = 1'b1;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 200) begin
      next_cycle();
      n++;
    end
    check(name, 32'(sb[0].size() + sb[1].size()), 0);
  endtask

  initial begin
    int a0, a1, p0, p1, cyc;

    repeat (3) @(negedge clk);
    check("rst_range_err", 32'(range_err[0]), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(addr_ready[0]), 1);
    check("range_err_after_rst", 32'(range_err[0]), 0);

    // single fetch
    data_ready = 1'b1;
    next_cycle();
    addr_valid = 1'b1; x = 6'd3; y = 6'd2;
    @(negedge clk);
    check("t1_mem_addr", 32'(mem_addr[0]), 85);
    check("t1_rd_en", 32'(mem_rd_en[0]), 1);
    next_cycle();
    addr_valid = 1'b0;
    @(negedge clk);
    check("t1_dv_t1", 32'(data_valid[0]), 0);
    @(negedge clk);
    check("t1_dv_t2", 32'(data_valid[0]), 1);
    check("t1_data", 32'(data[0]), 32'h100);
    check("t1_x", 32'(data_x[0]), 3);
    check("t1_y", 32'(data_y[0]), 2);
    drain("t1_drain");

    // back-to-back stream
    for (int i = 0; i < 26; i++) begin
      next_cycle();
      addr_valid = (i < 24);
      x = 6'(i);
      y = 6'd0;
      @(negedge clk);
      if (i < 24) check("t2_ready", 32'(addr_ready[0]), 1);
      if (i >= 2) check("t2_beat", 32'(data_valid[0]), 1);
    end
    drain("t2_drain");

    // back-pressure
    next_cycle();
    a0 = acc_cnt[0]; a1 = acc_cnt[1]; p0 = pop_cnt[0]; p1 = pop_cnt[1];
    data_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) next_cycle();
      addr_valid = 1'b1;
      x = 6'(c);
      y = 6'd1;
      @(negedge clk);
      if (c == 19) begin
        check("t3_ready_low", 32'(addr_ready[0]), 0);
        check("t3_no_rd_en", 32'(mem_rd_en[0]), 0);
      end
    end
    next_cycle();
    addr_valid = 1'b0;
    check("t3_accepts0", 32'(acc_cnt[0] - a0), 4);
    check("t3_accepts1", 32'(acc_cnt[1] - a1), 5);
    drain("t3_drain");
    check("t3_delivered0", 32'(pop_cnt[0] - p0), 4);
    check("t3_delivered1", 32'(pop_cnt[1] - p1), 5);

    // randomized traffic
    a0 = acc_cnt[0];
    cyc = 0;
    while ((acc_cnt[0] - a0) < 2000 && cyc < 20000) begin
      next_cycle();
      addr_valid = 1'($urandom);
      x = 6'($urandom_range(0, 40));
      y = 6'($urandom_range(0, 49));
      data_ready = 1'($urandom);
      cyc++;
    end
    check("t4_reached_2000", 32'((acc_cnt[0] - a0) >= 2000), 1);
    drain("t4_drain");

    // out-of-range coordinate
    check("t5_err_before", 32'(range_err[0]), 0);
    next_cycle();
    addr_valid = 1'b1; x = 6'd41; y = 6'd0;
    @(negedge clk);
    check("t5_err_same_cycle", 32'(range_err[0]), 0);
    check("t5_addr", 32'(mem_addr[0]), 41);
    next_cycle();
    x = 6'd5; y = 6'd5;
    @(negedge clk);
    check("t5_err_set0", 32'(range_err[0]), 1);
    check("t5_err_set1", 32'(range_err[1]), 1);
    repeat (3) next_cycle();
    drain("t5_drain");
    check("t5_err_held", 32'(range_err[0]), 1);

    // reset mid-burst: 3 in flight and 2 buffered on the latency-3 instance
    data_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      addr_valid = 1'b1; x = 6'(c); y = 6'd3;
      @(negedge clk);
      if (c == 4) check("t6_pre_dv1", 32'(data_valid[1]), 1);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    addr_valid = 1'b0;
    data_ready = 1'b1;
    @(negedge clk);
    check("t6_dv0_after", 32'(data_valid[0]), 0);
    check("t6_dv1_after", 32'(data_valid[1]), 0);
    check("t6_err_cleared", 32'(range_err[0]), 0);
    repeat (6) begin
      @(negedge clk);
      check("t6_no_stale0", 32'(data_valid[0]), 0);
      check("t6_no_stale1", 32'(data_valid[1]), 0);
    end
    next_cycle();
    addr_valid = 1'b1; x = 6'd0; y = 6'd49;
    @(negedge clk);
    check("t6_addr0", 32'(mem_addr[0]), 2009);
    check("t6_addr1", 32'(mem_addr[1]), 2009);
    check("t6_rd_en0", 32'(mem_rd_en[0]), 1);
    next_cycle();
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
